// File: rtl/sa_load_controller.sv
// sa_load_controller: streams NREG*N host elements into the SystolicArray register file with skewed IDX, then runs the matmul.
// Latency: each accepted element appears on the SA bus one cycle later; DONE follows the last beat by FLUSH_CYCLES+COMPUTE_CYCLES+1 edges.
// Backpressure: IN_READY is high only in LOAD; an edge without a beat drops SA_EN so the array freezes with the bus held.
module sa_load_controller #(
   parameter int DATA_W         = 16,
   parameter int N              = 8,
   parameter int NREG           = 16,
   parameter int IDX_W          = 5,
   parameter int FLUSH_CYCLES   = 2,
   parameter int COMPUTE_CYCLES = 30
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [DATA_W-1:0] IN_DATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              SA_EN,
   output logic              SA_RF_EN,
   output logic              SA_WRITE,
   output logic [IDX_W-1:0]  SA_IDX,
   output logic [DATA_W-1:0] SA_DIN,
   output logic [3:0]        SA_REG_SELECT
);

   localparam int BEATS  = NREG * N;
   localparam int BEAT_W = $clog2(BEATS);
   localparam int FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int CP_W   = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
   localparam logic [BEAT_W-1:0] N_B       = BEAT_W'(N);
   localparam logic [FL_W-1:0]   FL_LAST   = FL_W'(FLUSH_CYCLES - 1);
   localparam logic [CP_W-1:0]   CP_LAST   = CP_W'(COMPUTE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_FLUSH   = 3'd2,
      S_COMPUTE = 3'd3,
      S_FIN     = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [BEAT_W-1:0]   r_beat;
   logic [FL_W-1:0]     r_fl_cnt;
   logic [CP_W-1:0]     r_cp_cnt;

   logic                r_sa_en,    w_sa_en_nxt;
   logic                r_sa_rf_en, w_sa_rf_en_nxt;
   logic                r_sa_write, w_sa_write_nxt;
   logic [IDX_W-1:0]    r_sa_idx,   w_sa_idx_nxt;
   logic [DATA_W-1:0]   r_sa_din,   w_sa_din_nxt;
   logic [3:0]          r_sa_reg,   w_sa_reg_nxt;
   logic                r_done,     w_done_nxt;

   logic                w_in_ready;
   logic                w_beat;
   logic [BEAT_W-1:0]   w_row;
   logic [BEAT_W-1:0]   w_col;
   logic [BEAT_W-1:0]   w_idx_full;

   // Handshake: ready comes straight from the state register, never from IN_VALID.
   assign w_in_ready = (r_state == S_LOAD);
   assign w_beat     = IN_VALID & w_in_ready;

   // Skew: register i gets column j at IDX j+i, folded back by N for the second half of the registers.
   assign w_row      = r_beat / N_B;
   assign w_col      = (r_beat % N_B) + BEAT_W'(1);
   assign w_idx_full = (w_row < N_B) ? (w_col + w_row) : (w_col + w_row - N_B);

   // State register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state and next values of the registered array bus.
   always_comb begin
      w_state_nxt    = r_state;
      w_sa_en_nxt    = r_sa_en;
      w_sa_rf_en_nxt = r_sa_rf_en;
      w_sa_write_nxt = r_sa_write;
      w_sa_idx_nxt   = r_sa_idx;
      w_sa_din_nxt   = r_sa_din;
      w_sa_reg_nxt   = r_sa_reg;
      w_done_nxt     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_sa_en_nxt    = 1'b0;
            w_sa_rf_en_nxt = 1'b0;
            w_sa_write_nxt = 1'b0;
            w_sa_idx_nxt   = '0;
            w_sa_din_nxt   = '0;
            w_sa_reg_nxt   = '0;
            if (START) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            if (w_beat) begin
               w_sa_en_nxt    = 1'b1;
               w_sa_rf_en_nxt = 1'b1;
               w_sa_write_nxt = 1'b1;
               w_sa_idx_nxt   = IDX_W'(w_idx_full);
               w_sa_din_nxt   = IN_DATA;
               w_sa_reg_nxt   = 4'(w_row);
               if (r_beat == BEAT_LAST) w_state_nxt = S_FLUSH;
            end else begin
               w_sa_en_nxt = 1'b0;
            end
         end
         S_FLUSH: begin
            w_sa_en_nxt    = 1'b1;
            w_sa_rf_en_nxt = 1'b1;
            w_sa_write_nxt = 1'b1;
            if (r_fl_cnt == FL_LAST) w_state_nxt = S_COMPUTE;
         end
         S_COMPUTE: begin
            w_sa_en_nxt    = 1'b1;
            w_sa_rf_en_nxt = 1'b1;
            w_sa_write_nxt = 1'b0;
            if (r_cp_cnt == CP_LAST) w_state_nxt = S_FIN;
         end
         S_FIN: begin
            w_sa_en_nxt    = 1'b0;
            w_sa_rf_en_nxt = 1'b1;
            w_sa_write_nxt = 1'b0;
            w_done_nxt     = 1'b1;
            w_state_nxt    = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Beat, flush and compute counters: cleared outside their own state, saturating at terminal count.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_beat   <= '0;
         r_fl_cnt <= '0;
         r_cp_cnt <= '0;
      end else begin
         if (r_state != S_LOAD)                      r_beat <= '0;
         else if (w_beat && (r_beat != BEAT_LAST))   r_beat <= r_beat + BEAT_W'(1);

         if (r_state != S_FLUSH)                     r_fl_cnt <= '0;
         else if (r_fl_cnt != FL_LAST)               r_fl_cnt <= r_fl_cnt + FL_W'(1);

         if (r_state != S_COMPUTE)                   r_cp_cnt <= '0;
         else if (r_cp_cnt != CP_LAST)               r_cp_cnt <= r_cp_cnt + CP_W'(1);
      end
   end

   // Registered array bus and DONE pulse.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sa_en    <= 1'b0;
         r_sa_rf_en <= 1'b0;
         r_sa_write <= 1'b0;
         r_sa_idx   <= '0;
         r_sa_din   <= '0;
         r_sa_reg   <= '0;
         r_done     <= 1'b0;
      end else begin
         r_sa_en    <= w_sa_en_nxt;
         r_sa_rf_en <= w_sa_rf_en_nxt;
         r_sa_write <= w_sa_write_nxt;
         r_sa_idx   <= w_sa_idx_nxt;
         r_sa_din   <= w_sa_din_nxt;
         r_sa_reg   <= w_sa_reg_nxt;
         r_done     <= w_done_nxt;
      end
   end

   assign IN_READY      = w_in_ready;
   // BUSY stays up through the DONE cycle so the host sees one contiguous busy window.
   assign BUSY          = (r_state != S_IDLE) | r_done;
   assign DONE          = r_done;
   assign SA_EN         = r_sa_en;
   assign SA_RF_EN      = r_sa_rf_en;
   assign SA_WRITE      = r_sa_write;
   assign SA_IDX        = r_sa_idx;
   assign SA_DIN        = r_sa_din;
   assign SA_REG_SELECT = r_sa_reg;

endmodule

// File: tb/tb_sa_load_controller.sv
// Bench for sa_load_controller: scoreboarded write stream plus run-level latency/count checks.
module tb_sa_load_controller;

   logic        CLK, RST, START, START2, IN_VALID;
   logic [15:0] IN_DATA;
   logic        IN_READY, BUSY, DONE, SA_EN, SA_RF_EN, SA_WRITE;
   logic [4:0]  SA_IDX;
   logic [15:0] SA_DIN;
   logic [3:0]  SA_REG_SELECT;
   logic        d2_IN_READY, d2_BUSY, d2_DONE, d2_SA_EN, d2_SA_RF_EN, d2_SA_WRITE;
   logic [4:0]  d2_SA_IDX;
   logic [15:0] d2_SA_DIN;
   logic [3:0]  d2_SA_REG_SELECT;

   typedef struct {
      logic [3:0]  rs;
      logic [4:0]  idx;
      logic [15:0] din;
   } exp_t;

   exp_t   exp_q[$];
   int     n_checks = 0;
   int     n_errs   = 0;
   int     n_wr = 0, n_fl = 0, n_cp = 0, n_done = 0, n2_cp = 0, n2_done = 0;
   longint done_t = 0, d2_done_t = 0;
   logic   m_beat, m_rdy;
   logic        p_write;
   logic [4:0]  p_idx;
   logic [15:0] p_din;
   logic [3:0]  p_rs;
   logic [4:0]  obs_idx [2048];
   logic [3:0]  obs_rs  [2048];

   int spot_c [8] = '{0, 7, 24, 31, 64, 71, 120, 127};
   int spot_r [8] = '{0, 0, 3, 3, 8, 8, 15, 15};
   int spot_i [8] = '{1, 8, 4, 11, 1, 8, 8, 15};

   sa_load_controller dut (
      .CLK(CLK), .RST(RST), .START(START), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .IN_DATA(IN_DATA), .BUSY(BUSY), .DONE(DONE), .SA_EN(SA_EN), .SA_RF_EN(SA_RF_EN),
      .SA_WRITE(SA_WRITE), .SA_IDX(SA_IDX), .SA_DIN(SA_DIN), .SA_REG_SELECT(SA_REG_SELECT)
   );

   sa_load_controller #(.FLUSH_CYCLES(1), .COMPUTE_CYCLES(5)) dut2 (
      .CLK(CLK), .RST(RST), .START(START2), .IN_VALID(IN_VALID), .IN_READY(d2_IN_READY),
      .IN_DATA(IN_DATA), .BUSY(d2_BUSY), .DONE(d2_DONE), .SA_EN(d2_SA_EN), .SA_RF_EN(d2_SA_RF_EN),
      .SA_WRITE(d2_SA_WRITE), .SA_IDX(d2_SA_IDX), .SA_DIN(d2_SA_DIN), .SA_REG_SELECT(d2_SA_REG_SELECT)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errs++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, req);
      end
   endtask

   // Expected bus contents for beat c, element value c+1.
   function automatic exp_t model(input int c);
      exp_t e;
      int   i, j;
      i     = c / 8;
      j     = (c % 8) + 1;
      e.rs  = 4'(i);
      e.idx = (i < 8) ? 5'(j + i) : 5'(j + i - 8);
      e.din = 16'(c + 1);
      return e;
   endfunction

   // Handshake as seen at each active edge.
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_beat <= 1'b0;
         m_rdy  <= 1'b0;
      end else begin
         m_beat <= IN_VALID & IN_READY;
         m_rdy  <= IN_READY;
      end
   end

   // Monitor: classifies every cycle of the array bus and scores writes against the queue.
   always @(negedge CLK) begin : mon
      exp_t e;
      if (!RST) begin
         if (m_beat) begin
            if (n_wr < 2048) begin
               obs_idx[n_wr] = SA_IDX;
               obs_rs[n_wr]  = SA_REG_SELECT;
            end
            n_wr++;
            check("wr_ctl", 64'({SA_EN, SA_RF_EN, SA_WRITE}), 64'(3'b111));
            if (exp_q.size() == 0) begin
               check("wr_expected", 64'(0), 64'(1));
            end else begin
               e = exp_q.pop_front();
               check("wr_reg", 64'(SA_REG_SELECT), 64'(e.rs));
               check("wr_idx", 64'(SA_IDX), 64'(e.idx));
               check("wr_din", 64'(SA_DIN), 64'(e.din));
            end
         end else if (m_rdy) begin
            check("stall_en", 64'(SA_EN), 64'(0));
            check("stall_hold", 64'({SA_WRITE, SA_IDX, SA_DIN, SA_REG_SELECT}),
                  64'({p_write, p_idx, p_din, p_rs}));
         end else if (SA_EN) begin
            if (SA_WRITE) n_fl++;
            else          n_cp++;
            check("run_hold", 64'({SA_RF_EN, SA_IDX, SA_DIN, SA_REG_SELECT}),
                  64'({1'b1, p_idx, p_din, p_rs}));
         end
         if (DONE) begin
            n_done++;
            done_t = $time;
            check("fin_bus", 64'({SA_EN, SA_WRITE, SA_RF_EN}), 64'(3'b001));
         end
      end
      p_write = SA_WRITE;
      p_idx   = SA_IDX;
      p_din   = SA_DIN;
      p_rs    = SA_REG_SELECT;
      if (d2_SA_EN && !d2_SA_WRITE) n2_cp++;
      if (d2_DONE) begin
         n2_done++;
         d2_done_t = $time;
      end
   end

   task automatic run_test(input bit stall, input bit glitch, input bit with2, input int abort_at);
      int     c, stalls, cyc, k, wr0, fl0, cp0, dn0, n2cp0, n2dn0;
      longint t0;
      bit     acc;
      wr0 = n_wr; fl0 = n_fl; cp0 = n_cp; dn0 = n_done; n2cp0 = n2_cp; n2dn0 = n2_done;
      @(negedge CLK);
      START = 1'b1; START2 = with2; IN_VALID = 1'b0;
      @(posedge CLK);
      t0 = $time;
      @(negedge CLK);
      START = 1'b0; START2 = 1'b0;
      check("busy_run", 64'(BUSY), 64'(1));
      check("ready_load", 64'(IN_READY), 64'(1));
      c = 0; stalls = 0; cyc = 0;
      while (c < 128 && c != abort_at && cyc < 1000) begin
         IN_VALID = !stall || (cyc % 2 == 1);
         IN_DATA  = 16'(c + 1);
         START    = glitch && (cyc == 20);
         acc      = IN_VALID && IN_READY;
         if (!acc) stalls++;
         @(posedge CLK);
         if (acc) begin
            exp_q.push_back(model(c));
            c++;
         end
         @(negedge CLK);
         cyc++;
      end
      START = 1'b0;
      if (c == abort_at) return;
      check("load_beats", 64'(c), 64'(128));
      IN_DATA = 16'hDEAD;
      k = 0;
      while (n_done == dn0 && k < 400) begin
         START = glitch && (k == 0 || k == 10);
         @(negedge CLK);
         k++;
      end
      START = 1'b0;
      repeat (3) @(negedge CLK);
      check("done_count", 64'(n_done - dn0), 64'(1));
      check("done_edge", 64'((done_t - t0 - 5) / 10), 64'(161 + stalls));
      check("write_cycles", 64'(n_wr - wr0), 64'(128));
      check("flush_cycles", 64'(n_fl - fl0), 64'(2));
      check("compute_cycles", 64'(n_cp - cp0), 64'(30));
      check("queue_empty", 64'(exp_q.size()), 64'(0));
      check("idle_outs", 64'({BUSY, IN_READY, DONE, SA_EN, SA_RF_EN, SA_WRITE, SA_IDX, SA_DIN, SA_REG_SELECT}), 64'(0));
      for (int s = 0; s < 8; s++) begin
         check("spot_reg", 64'(obs_rs[wr0 + spot_c[s]]), 64'(spot_r[s]));
         check("spot_idx", 64'(obs_idx[wr0 + spot_c[s]]), 64'(spot_i[s]));
      end
      if (with2) begin
         check("ovr_compute", 64'(n2_cp - n2cp0), 64'(5));
         check("ovr_done_count", 64'(n2_done - n2dn0), 64'(1));
         check("ovr_done_edge", 64'((d2_done_t - t0 - 5) / 10), 64'(135));
      end
   endtask

   initial begin : main
      int dn;
      RST = 1'b1; START = 1'b0; START2 = 1'b0; IN_VALID = 1'b0; IN_DATA = '0;
      repeat (2) @(negedge CLK);
      check("reset_outs", 64'({IN_READY, BUSY, DONE, SA_EN, SA_RF_EN, SA_WRITE, SA_IDX, SA_DIN, SA_REG_SELECT}), 64'(0));
      RST = 1'b0;

      run_test(1'b0, 1'b0, 1'b1, -1);   // continuous, plus the short-parameter instance
      run_test(1'b1, 1'b0, 1'b0, -1);   // valid every other cycle
      run_test(1'b0, 1'b1, 1'b0, -1);   // stray START in LOAD/FLUSH/COMPUTE

      run_test(1'b0, 1'b0, 1'b0, 50);   // abort at beat 50
      check("pre_abort_ready", 64'(IN_READY), 64'(1));
      #2 RST = 1'b1;
      #1;
      check("async_reset", 64'({IN_READY, BUSY, DONE, SA_EN, SA_RF_EN, SA_WRITE, SA_IDX, SA_DIN, SA_REG_SELECT}), 64'(0));
      dn = n_done;
      exp_q.delete();
      @(negedge CLK);
      RST = 1'b0;
      repeat (200) @(negedge CLK);
      check("abort_no_done", 64'(n_done - dn), 64'(0));
      run_test(1'b0, 1'b0, 1'b0, -1);   // clean run after the abort

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
      $finish;
   end

endmodule
